// File: rtl/dcache_assoc_ctrl.sv
// Set-associative write-back / write-allocate data cache controller with LRU replacement.
// Lookup is combinational in StIdle; misses write back a dirty victim, then refill the line.
`timescale 1ns/1ps
module dcache_assoc_ctrl #(
  parameter int unsigned WAYS      = 2,
  parameter int unsigned SETS      = 16,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o
);
  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned OFF_W   = $clog2(LINE_BITS / 8);
  localparam int unsigned TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WORD_W  = OFF_W - 2;
  localparam int unsigned BITOFF_W = $clog2(LINE_BITS);

  typedef enum logic [1:0] {StIdle, StWbReq, StRfReq} state_e;

  state_e r_state, w_state_d;

  logic [LINE_BITS-1:0] r_data  [WAYS][SETS];
  logic [TAG_W-1:0]     r_tag   [WAYS][SETS];
  logic [SETS-1:0]      r_valid [WAYS];
  logic [SETS-1:0]      r_dirty [WAYS];
  logic [SETS-1:0]      r_lru;

  logic                 r_mem_en, r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [LINE_BITS-1:0] r_mem_data;
  logic                 r_victim;
  logic [TAG_W-1:0]     r_req_tag;
  logic [IDX_W-1:0]     r_req_idx;
  logic [31:0]          r_rdata;

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [WORD_W-1:0]    w_word;
  logic [BITOFF_W-1:0]  w_bit_off;
  logic                 w_req, w_hit, w_hit_way, w_victim, w_victim_dirty;
  logic                 w_idle_hit, w_miss, w_refill_done;
  logic [TAG_W-1:0]     w_wb_tag;
  logic [LINE_BITS-1:0] w_hit_line;
  logic [31:0]          w_hit_word;
  logic                 w_unused;

  assign w_idx     = p1_addr_i[OFF_W +: IDX_W];
  assign w_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign w_word    = p1_addr_i[OFF_W-1:2];
  assign w_bit_off = {w_word, 5'b0};
  assign w_req     = p1_MemRead_i | p1_MemWrite_i;
  assign w_unused  = ^p1_addr_i[1:0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 1'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the LRU pointer names the victim.
  always_comb begin
    w_victim = (WAYS == 2) ? r_lru[w_idx] : 1'b0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_victim = 1'(w);
    end
  end

  assign w_victim_dirty = r_dirty[w_victim][w_idx];
  assign w_wb_tag       = w_victim_dirty ? r_tag[w_victim][w_idx] : w_tag;
  assign w_hit_line     = r_data[w_hit_way][w_idx];
  assign w_hit_word     = w_hit_line[w_bit_off +: 32];
  assign w_idle_hit     = (r_state == StIdle) && w_req && w_hit;
  assign w_miss         = (r_state == StIdle) && w_req && !w_hit;
  assign w_refill_done  = (r_state == StRfReq) && r_mem_en && mem_ack_i;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_miss) w_state_d = w_victim_dirty ? StWbReq : StRfReq;
      StWbReq: if (r_mem_en && mem_ack_i) w_state_d = StRfReq;
      StRfReq: if (r_mem_en && mem_ack_i) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_lru   <= '0;
      r_rdata <= '0;
      for (int w = 0; w < int'(WAYS); w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_idle_hit) begin
        if (p1_MemWrite_i) r_dirty[w_hit_way][w_idx] <= 1'b1;
        if (p1_MemRead_i)  r_rdata <= w_hit_word;
        if (WAYS == 2)     r_lru[w_idx] <= ~w_hit_way;
      end
      if (w_refill_done) begin
        r_valid[r_victim][r_req_idx] <= 1'b1;
        r_dirty[r_victim][r_req_idx] <= 1'b0;
      end
    end
  end

  // Memory request registers; enable drops the cycle after ack, and a refill following a
  // write-back is raised from StRfReq only once enable has been low for a cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_victim   <= 1'b0;
      r_req_tag  <= '0;
      r_req_idx  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_miss) begin
            r_victim   <= w_victim;
            r_req_tag  <= w_tag;
            r_req_idx  <= w_idx;
            r_mem_en   <= 1'b1;
            r_mem_we   <= w_victim_dirty;
            r_mem_addr <= {w_wb_tag, w_idx, {OFF_W{1'b0}}};
            r_mem_data <= r_data[w_victim][w_idx];
          end
        end
        StWbReq: begin
          if (r_mem_en && mem_ack_i) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
          end
        end
        StRfReq: begin
          if (!r_mem_en) begin
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {r_req_tag, r_req_idx, {OFF_W{1'b0}}};
          end else if (mem_ack_i) begin
            r_mem_en <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_idle_hit && p1_MemWrite_i) r_data[w_hit_way][w_idx][w_bit_off +: 32] <= p1_data_i;
    if (w_refill_done) begin
      r_data[r_victim][r_req_idx] <= mem_data_i;
      r_tag[r_victim][r_req_idx]  <= r_req_tag;
    end
  end

  // Reset gates stall so an aborted request never holds the pipeline.
  assign p1_stall_o   = rst_i & w_req & ((r_state != StIdle) | !w_hit);
  assign p1_data_o    = (w_idle_hit && p1_MemRead_i) ? w_hit_word : r_rdata;
  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

endmodule
